tt_um_seq_divider_8x4: RTL and testbench
========================================

TT_UM_SEQ_DIVIDER_8X4 -- requirements
Module: tt_um_seq_divider_8x4

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 ui_in  input  8  dividend A[7:0].
REQ-005 uio_in  input  8  [3:0] divisor B; [4] start; [5] out_sel; [7:6] unused, ignored.
REQ-006 uo_out  output  8  out_sel=0: quotient Q[7:0]; out_sel=1: {4'b0000, remainder R[3:0]}; combinational mux of result registers.
REQ-007 uio_out  output  8  [7] done, [6] busy, [5] err; [4:0] SHALL be 0.
REQ-008 uio_oe  output  8  SHALL be constant 8'b1110_0000.

Function
REQ-009 The block SHALL compute A / B unsigned, with Q = floor(A/B) and R = A mod B, satisfying A = Q*B + R and R < B for B != 0.
REQ-010 The algorithm SHALL be restoring division, one quotient bit per cycle, MSB first, using a 5-bit partial remainder and a 3-bit iteration counter.
REQ-011 States: IDLE, RUN, DONE; reset state SHALL be IDLE.
REQ-012 start_q SHALL register uio_in[4] each cycle; an accepted start is uio_in[4]=1 and start_q=0 (rising edge) while in IDLE or DONE.
REQ-013 On an accepted start at edge N with B != 0: latch A and B into working registers, clear the partial remainder and counter, clear done and err, set busy, enter RUN.
REQ-014 In RUN, each of edges N+1 .. N+8 SHALL perform one iteration.
REQ-015 At edge N+8: write Q and R into the result registers, clear busy, set done, enter DONE.
REQ-016 Latency from accepted start to done=1 SHALL be exactly 8 cycles.
REQ-017 On an accepted start with B = 0: enter DONE at edge N directly; set Q=8'hFF, R=4'h0, err=1, done=1; busy SHALL stay 0.
REQ-018 The result registers and err SHALL hold their values until the next completion; uo_out SHALL show the previous result during RUN.
REQ-019 A start edge during RUN SHALL be ignored; operands SHALL be sampled only at acceptance.
REQ-020 Holding start high SHALL produce exactly one operation; a new one requires start low for at least one cycle.
REQ-021 done SHALL stay high in DONE until the next accepted start; busy and done SHALL never be high together.
REQ-022 out_sel SHALL affect only the uo_out mux, never state.

Reset
REQ-023 With rst_n=0 at a rising edge: state=IDLE; start_q, Q, R, working registers and counter SHALL be 0; busy=done=err=0.
REQ-024 After reset, uo_out SHALL be 8'h00 for either out_sel value.
REQ-025 Reset asserted during RUN SHALL abort the operation with no result written; uio_oe SHALL stay 8'b1110_0000 at all times.

Verification
REQ-026 A=200, B=7, start pulse -> busy for 8 cycles, then done=1, Q=28 (out_sel=0), R=4 (out_sel=1), err=0.
REQ-027 A=255, B=1 -> Q=255, R=0; A=5, B=9 -> Q=0, R=5; A=0, B=15 -> Q=0, R=0.
REQ-028 A=77, B=0 -> done=1 on the edge after acceptance, err=1, Q=8'hFF, R=0, busy never 1; a next start with B=3 clears err, giving Q=25, R=2.
REQ-029 start held high for 20 cycles with A=100, B=10 -> exactly one run; done=1 at 8 cycles with Q=10, R=0, and it remains done.
REQ-030 Start edge with new operands at cycle 3 of RUN -> ignored, first result unchanged; rst_n=0 at cycle 4 of a run -> all outputs 0, state IDLE, no done.
REQ-031 Exhaustive sweep of all 256x15 nonzero-divisor pairs -> Q and R match the reference model; each completes in exactly 8 cycles.

Source files
------------

// File: rtl/tt_um_seq_divider_8x4.sv
// Sequential 8-bit by 4-bit unsigned divider (restoring algorithm).
// One quotient bit per cycle, MSB first; a divide by zero completes
// immediately with an error flag and a saturated quotient.
//
// state | meaning
// IDLE  | no result produced since reset, waiting for a start edge
// RUN   | eight restoring iterations in progress, busy=1
// DONE  | result registers valid, done=1, waiting for a start edge
module tt_um_seq_divider_8x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        start_q;
    logic [7:0]  a_work;
    logic [3:0]  b_work;
    logic [4:0]  rem_q;
    logic [2:0]  cnt_q;
    logic [7:0]  quo_q;
    logic [3:0]  res_rem_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic        start_edge;
    logic        div_zero;
    logic        accept;
    logic        last_iter;
    logic [4:0]  trial;
    logic        take;
    logic [4:0]  rem_next;
    logic [7:0]  a_next;
    logic        unused_ok;

    assign start_edge = uio_in[4] & ~start_q;
    assign div_zero   = (uio_in[3:0] == 4'd0);

    // Partial remainder is always below the divisor, so its low nibble
    // plus the next dividend bit forms the full 5-bit trial value.
    assign trial    = {rem_q[3:0], a_work[7]};
    assign take     = (trial >= {1'b0, b_work});
    assign rem_next = take ? (trial - {1'b0, b_work}) : trial;
    assign a_next   = {a_work[6:0], take};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the accept / last-iteration strobes.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    accept  = 1'b1;
                    state_d = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == 3'd7) begin
                    last_iter = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration datapath, result registers and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q   <= 1'b0;
            a_work    <= 8'd0;
            b_work    <= 4'd0;
            rem_q     <= 5'd0;
            cnt_q     <= 3'd0;
            quo_q     <= 8'd0;
            res_rem_q <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            start_q <= uio_in[4];
            if (accept) begin
                if (div_zero) begin
                    quo_q     <= 8'hFF;
                    res_rem_q <= 4'h0;
                    err_q     <= 1'b1;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                end else begin
                    a_work <= ui_in;
                    b_work <= uio_in[3:0];
                    rem_q  <= 5'd0;
                    cnt_q  <= 3'd0;
                    err_q  <= 1'b0;
                    done_q <= 1'b0;
                    busy_q <= 1'b1;
                end
            end else if (state_q == RUN) begin
                a_work <= a_next;
                rem_q  <= rem_next;
                cnt_q  <= cnt_q + 3'd1;
                if (last_iter) begin
                    quo_q     <= a_next;
                    res_rem_q <= rem_next[3:0];
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign uo_out    = uio_in[5] ? {4'b0000, res_rem_q} : quo_q;
    assign uio_out   = {done_q, busy_q, err_q, 5'b00000};
    assign uio_oe    = 8'b1110_0000;
    assign unused_ok = &{1'b0, uio_in[7:6], rem_q[4]};

endmodule

// File: tb/tb_tt_um_seq_divider_8x4.sv
// Self-checking bench for the 8x4 sequential divider: directed corner
// cases, an exhaustive nonzero-divisor sweep and random operations, all
// compared against plain integer division.
module tb_tt_um_seq_divider_8x4;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec = 0;
    int n_err = 0;

    tt_um_seq_divider_8x4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Invariants sampled every cycle: busy/done exclusive, fixed OE, low bits zero.
    always @(negedge clk) begin
        chk("invariants", {23'd0, uio_out[7] & uio_out[6], uio_oe, uio_out[4:0]},
            {23'd0, 1'b0, 8'hE0, 5'd0});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reads both mux settings and the error flag against the reference.
    task automatic check_result(input string tag, input logic [7:0] q, input logic [3:0] r,
                                input logic e);
        uio_in[5] = 1'b0;
        #1;
        chk({tag, "_q"}, uo_out, q);
        uio_in[5] = 1'b1;
        #1;
        chk({tag, "_r"}, uo_out, {4'b0000, r});
        chk({tag, "_err"}, uio_out[5], e);
        chk({tag, "_done"}, uio_out[7], 1'b1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [3:0] b);
        int          cyc;
        logic [7:0]  q_ref;
        logic [3:0]  r_ref;
        if (b == 4'd0) begin
            q_ref = 8'hFF;
            r_ref = 4'h0;
        end else begin
            q_ref = 8'(int'(a) / int'(b));
            r_ref = 4'(int'(a) % int'(b));
        end
        @(negedge clk);
        ui_in  = a;
        uio_in = {2'b00, 1'($urandom), 1'b1, b};
        tick();
        if (b == 4'd0) begin
            chk("dz_flags", uio_out[7:5], 3'b101);
        end else begin
            chk("accept_flags", uio_out[7:5], 3'b010);
        end
        @(negedge clk);
        uio_in[4] = 1'b0;
        uio_in[5] = 1'($urandom);
        cyc = 0;
        while (!uio_out[7] && cyc < 20) begin
            tick();
            cyc++;
        end
        if (b != 4'd0) chk("latency", cyc, 8);
        check_result("op", q_ref, r_ref, b == 4'd0);
    endtask

    initial begin
        int cyc;
        rst_n  = 1'b0;
        ui_in  = 8'd0;
        uio_in = 8'd0;
        tick();
        tick();
        chk("rst_flags", uio_out, 8'h00);
        uio_in[5] = 1'b0;
        #1;
        chk("rst_q", uo_out, 8'h00);
        uio_in[5] = 1'b1;
        #1;
        chk("rst_r", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd200, 4'd7);
        run_op(8'd255, 4'd1);
        run_op(8'd5, 4'd9);
        run_op(8'd0, 4'd15);
        run_op(8'd77, 4'd0);
        run_op(8'd77, 4'd3);

        // Start held high for 20 cycles: exactly one operation.
        @(negedge clk);
        ui_in  = 8'd100;
        uio_in = {2'b00, 1'b0, 1'b1, 4'd10};
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("hold_done", uio_out[7], i >= 9);
            chk("hold_busy", uio_out[6], i < 9);
        end
        check_result("hold", 8'd10, 4'd0, 1'b0);
        @(negedge clk);
        uio_in[4] = 1'b0;

        // Start edge with new operands during RUN is ignored.
        @(negedge clk);
        ui_in  = 8'd50;
        uio_in = {2'b00, 1'b0, 1'b1, 4'd3};
        tick();
        @(negedge clk);
        uio_in[4] = 1'b0;
        tick();
        tick();
        @(negedge clk);
        ui_in  = 8'd9;
        uio_in = {2'b00, 1'b0, 1'b1, 4'd2};
        tick();
        @(negedge clk);
        uio_in[4] = 1'b0;
        cyc = 0;
        while (!uio_out[7] && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("ign_latency", cyc, 5);
        check_result("ign", 8'd16, 4'd2, 1'b0);
        tick();
        tick();
        tick();
        check_result("ign_hold", 8'd16, 4'd2, 1'b0);

        // Reset in the fourth cycle of a run aborts with nothing written.
        @(negedge clk);
        ui_in  = 8'd200;
        uio_in = {2'b00, 1'b0, 1'b1, 4'd7};
        tick();
        @(negedge clk);
        uio_in[4] = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        chk("abort_flags", uio_out, 8'h00);
        uio_in[5] = 1'b0;
        #1;
        chk("abort_q", uo_out, 8'h00);
        uio_in[5] = 1'b1;
        #1;
        chk("abort_r", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("abort_idle", uio_out, 8'h00);

        // Exhaustive sweep of nonzero divisors.
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                run_op(8'(a), 4'(b));
            end
        end

        // Random operations, divide-by-zero included.
        for (int i = 0; i < 300; i++) begin
            run_op(8'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
